// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
//   XLEN_DEF : default data/address width
//   MASK_W   : byte-enable width for the default width
//   state_e  : arbiter FSM states
//   owner_e  : which port owns the outstanding access
package rv_mem_pkg;

    localparam int XLEN_DEF = 32;
    localparam int MASK_W   = XLEN_DEF / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/rv_arb_fair.sv
// Two-requester priority selector with a starvation guard for fetch.
// Data wins a conflict unless it has already won MAX_DWIN conflicts in a
// row, in which case fetch is forced through. Grants are one-hot and only
// produced while en_i is high.
//   clock, reset : system clock, async active-low reset
//   en_i         : issue window open
//   if_req_i     : fetch request
//   d_req_i      : data request
//   if_gnt_o     : fetch granted this cycle
//   d_gnt_o      : data granted this cycle
module rv_arb_fair #(
    parameter int MAX_DWIN = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic if_gnt_o,
    output logic d_gnt_o
);

    // one spare code so the counter can hold MAX_DWIN itself, also for MAX_DWIN=0
    localparam int DW_W = $clog2(MAX_DWIN + 2);
    localparam logic [DW_W-1:0] DWIN_MAX = DW_W'(MAX_DWIN);

    logic [DW_W-1:0] dwin_q, dwin_d;
    logic            conflict;

    assign conflict = if_req_i && d_req_i;

    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        dwin_d   = dwin_q;
        if (en_i) begin
            if (conflict) begin
                if (dwin_q == DWIN_MAX) begin
                    if_gnt_o = 1'b1;
                end else begin
                    d_gnt_o = 1'b1;
                end
            end else begin
                if_gnt_o = if_req_i;
                d_gnt_o  = d_req_i;
            end
        end
        // only contested wins count against fetch; any fetch grant resets the tally
        if (if_gnt_o) begin
            dwin_d = '0;
        end else if (d_gnt_o && conflict) begin
            dwin_d = dwin_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dwin_q <= '0;
        end else begin
            dwin_q <= dwin_d;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between the core's
// fetch port and data port. One access outstanding at a time; a new access
// may issue in the same cycle the previous response returns.
//
// state | meaning
// IDLE  | no access outstanding
// BUSY  | access outstanding, owner_q holds the port, cnt_q counts 1..MEM_LAT
//
// Ports:
//   clock, reset                 : system clock, async active-low reset
//   if_req/if_addr               : fetch request and byte address
//   if_gnt/if_rvalid/if_rdata    : fetch grant, response strobe, instruction
//   d_req/d_we/d_addr/d_wdata/d_mask : data request fields
//   d_gnt/d_rvalid/d_rdata       : data grant, response strobe, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_mask : memory access
//   mem_rdata                    : memory read data, MEM_LAT cycles after mem_en
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MEM_LAT  = 1,
    parameter int MAX_DWIN = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_mask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_mask,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             resp;
    logic             issue_win;

    assign resp = (state_q == BUSY) && (cnt_q == LAT_C);

    // reset gates the window directly so grants and mem_* read 0 while it is held
    assign issue_win = reset && ((state_q == IDLE) || resp);

    rv_arb_fair #(
        .MAX_DWIN (MAX_DWIN)
    ) u_arb (
        .clock    (clock),
        .reset    (reset),
        .en_i     (issue_win),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .if_gnt_o (if_gnt),
        .d_gnt_o  (d_gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            BUSY: begin
                if (resp) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (owner_q == OWN_D) begin
                        d_rvalid = 1'b1;
                        // stores are acknowledged with zero data
                        if (!we_q) begin
                            d_rdata = mem_rdata;
                        end
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_mask  = d_mask;
            owner_d   = OWN_D;
            we_d      = d_we;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            mem_mask  = '1;
            owner_d   = OWN_IF;
            we_d      = 1'b0;
        end

        // an issue in the response cycle overrides the return to IDLE
        if (d_gnt || if_gnt) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Three arbiter instances (MEM_LAT = 1, 2, 3) receive the same request
// stream. A timestamp-based model predicts every output each cycle; literal
// expectations pin grant order, latencies and data for each scenario.
module tb_rv_mem_arbiter;

    localparam int NL       = 3;
    localparam int MAX_DWIN = 2;
    localparam int TAB      = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        if_req    [NL];
    logic [31:0] if_addr   [NL];
    logic        if_gnt    [NL];
    logic        if_rvalid [NL];
    logic [31:0] if_rdata  [NL];
    logic        d_req     [NL];
    logic        d_we      [NL];
    logic [31:0] d_addr    [NL];
    logic [31:0] d_wdata   [NL];
    logic [3:0]  d_mask    [NL];
    logic        d_gnt     [NL];
    logic        d_rvalid  [NL];
    logic [31:0] d_rdata   [NL];
    logic        mem_en    [NL];
    logic        mem_we    [NL];
    logic [31:0] mem_addr  [NL];
    logic [31:0] mem_wdata [NL];
    logic [3:0]  mem_mask  [NL];
    logic [31:0] mem_rdata [NL];

    for (genvar g = 0; g < NL; g++) begin : lane
        rv_mem_arbiter #(
            .XLEN     (32),
            .MEM_LAT  (g + 1),
            .MAX_DWIN (MAX_DWIN)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_mask    (d_mask[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_mask  (mem_mask[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // request tables shared by all lanes; each lane consumes at its own pace
    logic [31:0] it_addr [TAB];
    int          it_n = 0;
    logic        dt_we    [TAB];
    logic [31:0] dt_addr  [TAB];
    logic [31:0] dt_wdata [TAB];
    logic [3:0]  dt_mask  [TAB];
    int          dt_n = 0;
    int          it_p [NL];
    int          dt_p [NL];

    // memory read pipeline per lane
    logic        mv      [NL][4];
    logic [31:0] ma      [NL][4];
    logic        pend_rd [NL];
    logic [31:0] pend_a  [NL];

    // model state
    logic        m_busy  [NL];
    int          m_iss   [NL];
    logic        m_own_d [NL];
    logic        m_we    [NL];
    logic [31:0] m_addr  [NL];
    int          m_dwin  [NL];

    // logs taken from the DUT for literal checks
    byte         ord   [NL][64];
    int          gc    [NL][64];
    int          ord_n [NL];
    logic [31:0] frd   [NL][64];
    int          frd_n [NL];
    logic [31:0] drd   [NL][64];
    int          drd_n [NL];
    int          rv_total [NL];
    int          g_if_cyc [NL];
    int          g_d_cyc  [NL];
    int          rv_if_cyc [NL];
    int          rv_d_cyc  [NL];
    logic        ld_we    [NL];
    logic [31:0] ld_addr  [NL];
    logic [31:0] ld_wdata [NL];
    logic [3:0]  ld_mask  [NL];
    int          bi [NL];
    int          bf [NL];
    int          bd [NL];
    int          brv [NL];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input int l, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d cyc=%0d got=%h exp=%h", name, l, cyc, act, exp);
        end
    endtask

    task automatic push_if(input logic [31:0] a);
        it_addr[it_n] = a;
        it_n++;
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m);
        dt_we[dt_n]    = we;
        dt_addr[dt_n]  = a;
        dt_wdata[dt_n] = wd;
        dt_mask[dt_n]  = m;
        dt_n++;
    endtask

    task automatic drive();
        for (int l = 0; l < NL; l++) begin
            if_req[l]  = it_p[l] < it_n;
            if_addr[l] = if_req[l] ? it_addr[it_p[l]] : 32'h0;
            d_req[l]   = dt_p[l] < dt_n;
            d_we[l]    = d_req[l] ? dt_we[dt_p[l]] : 1'b0;
            d_addr[l]  = d_req[l] ? dt_addr[dt_p[l]] : 32'h0;
            d_wdata[l] = d_req[l] ? dt_wdata[dt_p[l]] : 32'h0;
            d_mask[l]  = d_req[l] ? dt_mask[dt_p[l]] : 4'h0;
            for (int k = 3; k > 0; k--) begin
                mv[l][k] = mv[l][k-1];
                ma[l][k] = ma[l][k-1];
            end
            mv[l][0] = pend_rd[l];
            ma[l][0] = pend_a[l];
            // lane l has latency l+1, so its data leaves stage l
            mem_rdata[l] = mv[l][l] ? memf(ma[l][l]) : 32'hDEAD_BEEF;
        end
    endtask

    task automatic model_check();
        for (int l = 0; l < NL; l++) begin
            int          lat;
            logic        conflict, resp, win, e_ig, e_dg, e_irv, e_drv, e_en, e_we;
            logic [31:0] e_ird, e_drd, e_addr, e_wd;
            logic [3:0]  e_mask;
            lat      = l + 1;
            conflict = if_req[l] && d_req[l];
            resp = 1'b0; e_ig = 1'b0; e_dg = 1'b0;
            if (!reset) begin
                m_busy[l] = 1'b0;
                m_dwin[l] = 0;
            end else begin
                resp = m_busy[l] && (cyc - m_iss[l] == lat);
                win  = !m_busy[l] || resp;
                if (win) begin
                    if (conflict) begin
                        e_ig = (m_dwin[l] == MAX_DWIN);
                        e_dg = !e_ig;
                    end else begin
                        e_ig = if_req[l];
                        e_dg = d_req[l];
                    end
                end
            end
            e_irv  = resp && !m_own_d[l];
            e_drv  = resp && m_own_d[l];
            e_ird  = e_irv ? memf(m_addr[l]) : 32'h0;
            e_drd  = (e_drv && !m_we[l]) ? memf(m_addr[l]) : 32'h0;
            e_en   = e_ig || e_dg;
            e_we   = e_dg && d_we[l];
            e_addr = e_dg ? d_addr[l] : (e_ig ? if_addr[l] : 32'h0);
            e_wd   = e_dg ? d_wdata[l] : 32'h0;
            e_mask = e_dg ? d_mask[l] : (e_ig ? 4'hF : 4'h0);

            chk("if_gnt", l, 32'(if_gnt[l]), 32'(e_ig));
            chk("d_gnt", l, 32'(d_gnt[l]), 32'(e_dg));
            chk("gnt_onehot", l, 32'(if_gnt[l] && d_gnt[l]), 32'h0);
            chk("if_rvalid", l, 32'(if_rvalid[l]), 32'(e_irv));
            chk("d_rvalid", l, 32'(d_rvalid[l]), 32'(e_drv));
            chk("if_rdata", l, if_rdata[l], e_ird);
            chk("d_rdata", l, d_rdata[l], e_drd);
            chk("mem_en", l, 32'(mem_en[l]), 32'(e_en));
            chk("mem_we", l, 32'(mem_we[l]), 32'(e_we));
            chk("mem_addr", l, mem_addr[l], e_addr);
            chk("mem_mask", l, 32'(mem_mask[l]), 32'(e_mask));
            if (!e_ig) chk("mem_wdata", l, mem_wdata[l], e_wd);

            if (resp) m_busy[l] = 1'b0;
            if (e_en) begin
                m_busy[l]  = 1'b1;
                m_iss[l]   = cyc;
                m_own_d[l] = e_dg;
                m_we[l]    = e_we;
                m_addr[l]  = e_addr;
            end
            if (e_ig) m_dwin[l] = 0;
            else if (e_dg && conflict) m_dwin[l]++;

            if (if_gnt[l]) begin
                it_p[l]++;
                ord[l][ord_n[l]] = "I";
                gc[l][ord_n[l]]  = cyc;
                ord_n[l]++;
                g_if_cyc[l] = cyc;
            end
            if (d_gnt[l]) begin
                dt_p[l]++;
                ord[l][ord_n[l]] = "D";
                gc[l][ord_n[l]]  = cyc;
                ord_n[l]++;
                g_d_cyc[l]  = cyc;
                ld_we[l]    = mem_we[l];
                ld_addr[l]  = mem_addr[l];
                ld_wdata[l] = mem_wdata[l];
                ld_mask[l]  = mem_mask[l];
            end
            if (if_rvalid[l]) begin
                frd[l][frd_n[l]] = if_rdata[l];
                frd_n[l]++;
                rv_if_cyc[l] = cyc;
                rv_total[l]++;
            end
            if (d_rvalid[l]) begin
                drd[l][drd_n[l]] = d_rdata[l];
                drd_n[l]++;
                rv_d_cyc[l] = cyc;
                rv_total[l]++;
            end
            pend_rd[l] = mem_en[l] && !mem_we[l];
            pend_a[l]  = mem_addr[l];
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clock);
        model_check();
        @(posedge clock);
        #1;
        drive();
    endtask

    function automatic bit pending();
        for (int l = 0; l < NL; l++)
            if (it_p[l] < it_n || dt_p[l] < dt_n || m_busy[l]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        while (pending() && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_done_in_time"}, 0, 32'(n < 200), 32'h1);
        step();
        step();
    endtask

    task automatic mark();
        for (int l = 0; l < NL; l++) begin
            bi[l]  = ord_n[l];
            bf[l]  = frd_n[l];
            bd[l]  = drd_n[l];
            brv[l] = rv_total[l];
        end
    endtask

    task automatic check_order(input string tag, input string s);
        for (int l = 0; l < NL; l++) begin
            chk({tag, "_ngrant"}, l, ord_n[l] - bi[l], s.len());
            for (int i = 0; i < s.len(); i++)
                chk({tag, "_order"}, l, 32'(ord[l][bi[l] + i]), 32'(s[i]));
        end
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            it_p[l] = 0; dt_p[l] = 0;
            pend_rd[l] = 1'b0; pend_a[l] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                mv[l][k] = 1'b0;
                ma[l][k] = 32'h0;
            end
            m_busy[l] = 1'b0; m_iss[l] = 0; m_own_d[l] = 1'b0;
            m_we[l] = 1'b0; m_addr[l] = 32'h0; m_dwin[l] = 0;
            ord_n[l] = 0; frd_n[l] = 0; drd_n[l] = 0; rv_total[l] = 0;
        end
        reset = 1'b0;
        drive();
        repeat (3) step();
        for (int l = 0; l < NL; l++) begin
            chk("rst_mem_en", l, 32'(mem_en[l]), 32'h0);
            chk("rst_if_rdata", l, if_rdata[l], 32'h0);
        end
        reset = 1'b1;
        step();

        // fetch only
        mark();
        push_if(32'h0); push_if(32'h4); push_if(32'h8);
        run_idle("fetch");
        check_order("fetch", "III");
        for (int l = 0; l < NL; l++) begin
            chk("fetch_nresp", l, frd_n[l] - bf[l], 3);
            chk("fetch_rd0", l, frd[l][bf[l]], 32'hC0DE_0000);
            chk("fetch_rd1", l, frd[l][bf[l] + 1], 32'hC0DE_0004);
            chk("fetch_rd2", l, frd[l][bf[l] + 2], 32'hC0DE_0008);
            for (int i = 0; i < 2; i++)
                chk("fetch_gap", l, gc[l][bi[l] + i + 1] - gc[l][bi[l] + i], l + 1);
        end

        // conflict: both ports held
        mark();
        push_d(1'b0, 32'h100, 32'h0, 4'hF); push_d(1'b0, 32'h104, 32'h0, 4'hF);
        push_d(1'b0, 32'h108, 32'h0, 4'hF); push_d(1'b0, 32'h10C, 32'h0, 4'hF);
        push_if(32'h200); push_if(32'h204);
        run_idle("conflict");
        check_order("conflict", "DDIDDI");
        for (int l = 0; l < NL; l++) begin
            chk("conflict_span", l, gc[l][bi[l] + 5] - gc[l][bi[l]], 5 * (l + 1));
            chk("conflict_load0", l, drd[l][bd[l]], 32'hC0DE_0100);
        end

        // store
        mark();
        push_d(1'b1, 32'h64, 32'h19, 4'b0001);
        run_idle("store");
        check_order("store", "D");
        for (int l = 0; l < NL; l++) begin
            chk("store_we", l, 32'(ld_we[l]), 32'h1);
            chk("store_addr", l, ld_addr[l], 32'h64);
            chk("store_wdata", l, ld_wdata[l], 32'h19);
            chk("store_mask", l, 32'(ld_mask[l]), 32'h1);
            chk("store_ack_n", l, drd_n[l] - bd[l], 1);
            chk("store_rdata", l, drd[l][bd[l]], 32'h0);
            chk("store_lat", l, rv_d_cyc[l] - g_d_cyc[l], l + 1);
        end

        // back-to-back: load then fetch
        mark();
        push_d(1'b0, 32'h300, 32'h0, 4'hF);
        push_if(32'h400);
        run_idle("b2b");
        check_order("b2b", "DI");
        for (int l = 0; l < NL; l++) begin
            chk("b2b_issue_at_resp", l, g_if_cyc[l], rv_d_cyc[l]);
            chk("b2b_gap", l, g_if_cyc[l] - g_d_cyc[l], l + 1);
            chk("b2b_if_lat", l, rv_if_cyc[l] - g_if_cyc[l], l + 1);
            chk("b2b_load", l, drd[l][bd[l]], 32'hC0DE_0300);
            chk("b2b_fetch", l, frd[l][bf[l]], 32'hC0DE_0400);
        end

        // reset one cycle after a load is granted
        mark();
        push_d(1'b0, 32'h500, 32'h0, 4'hF);
        step();
        step();
        reset = 1'b0;
        step();
        for (int l = 0; l < NL; l++) begin
            chk("rst_held_d_rvalid", l, 32'(d_rvalid[l]), 32'h0);
            chk("rst_held_mem_en", l, 32'(mem_en[l]), 32'h0);
        end
        step();
        reset = 1'b1;
        repeat (6) step();
        for (int l = 0; l < NL; l++) begin
            chk("rst_load_granted", l, ord_n[l] - bi[l], 1);
            chk("rst_no_rvalid", l, rv_total[l] - brv[l], 0);
        end

        // starvation counter was cleared by reset: data wins twice before fetch
        mark();
        push_d(1'b0, 32'h600, 32'h0, 4'hF); push_d(1'b0, 32'h604, 32'h0, 4'hF);
        push_if(32'h700);
        run_idle("post_rst");
        check_order("post_rst", "DDI");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the `riscv` core's fetch port (`PC`/`Instr`) and data port (`DataAdr`/`WriteData`/`mask`/`MemWrite`/`ReadData`). It sits between the core and the memory, inside the `rv32i` top.
- Data accesses have priority, with a starvation guard for fetch.
- One transaction is outstanding at a time; a new one may issue back-to-back on the cycle the previous response returns.
- Memory read latency is fixed and set by parameter.

## Interface
- `XLEN`, 32, data/address width
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4)
- `MAX_DWIN`, 2, consecutive conflict wins allowed to the data port before fetch is forced
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `if_req`  in  1  fetch request, held until granted
- `if_addr`  in  XLEN  fetch byte address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch response valid
- `if_rdata`  out  XLEN  fetch instruction word
- `d_req`  in  1  data request, held until granted
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  XLEN  data byte address
- `d_wdata`  in  XLEN  store data
- `d_mask`  in  XLEN/8  byte enables
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data response (load data or store ack)
- `d_rdata`  out  XLEN  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  XLEN  memory byte address
- `mem_wdata`  out  XLEN  memory write data
- `mem_mask`  out  XLEN/8  memory byte enables
- `mem_rdata`  in  XLEN  memory read data, valid `MEM_LAT` cycles after `mem_en`

## Operation
- **State machine:**
  - `IDLE`: no access outstanding.
  - `BUSY`: an access is outstanding. The register `owner` (IF/D) records the port, and `cnt` counts 1..`MEM_LAT`.
- **Issue window:** asserted when the state is `IDLE`, or when the state is `BUSY` and `cnt == MEM_LAT` (the response cycle).
- **Arbitration** (combinational, only inside the issue window):
  - Only one port requesting: that port wins.
  - Both requesting: `d` wins, unless `dwin == MAX_DWIN`, in which case `if` wins.
  - `dwin` increments on each conflict won by `d` and clears on any `if` grant.
- **Issue:** the winner's `gnt` pulses for 1 cycle and `mem_en` is 1 in the same cycle. The `mem_*` fields come from the winner:
  - fetch: `mem_we` = 0, `mem_mask` = all ones.
  - data: fields come straight from the `d_*` inputs.
  - The next state is `BUSY` with `cnt` = 1 and `owner` = winner.
- **Counting:** in `BUSY`, `cnt` increments each cycle.
- **Response** (when `cnt == MEM_LAT`):
  - The `owner`'s `rvalid` is 1 for exactly that cycle.
  - `rdata` passes combinationally from `mem_rdata`. A store still produces `d_rvalid`, with `d_rdata` driven to 0.
  - No new issue → `IDLE`. New issue → stay in `BUSY` with `cnt` = 1.
- **Address handling:** addresses pass through unmodified; alignment is the core's responsibility.
- **Outputs when idle:** with no grant, `mem_*` outputs and inactive `rdata` outputs are driven to 0.
- **Reset:** `reset` low clears `state`→`IDLE`, `cnt`→0, `owner`→IF, `dwin`→0.
  - All outputs are 0 while reset is held.
  - A reset mid-access abandons the access: no `rvalid` is produced after release.

## Timing
- Grant to response is `MEM_LAT` cycles: issue at T, `rvalid` at T+`MEM_LAT`.
- Peak throughput is 1 access per `MEM_LAT` cycles.
- `gnt` and `mem_en` are combinational from `req` plus registered state. There is no combinational path from `mem_rdata` to any `gnt`.
- A requester must hold `req`, `addr`, `we`, `wdata` and `mask` stable until its `gnt` cycle; they may change the cycle after.
- `if_gnt` and `d_gnt` are never both 1 in the same cycle.

## Structure
- Package `rv_mem_pkg`: `XLEN` default, `MASK_W = XLEN/8`, state enum {`IDLE`, `BUSY`}, owner enum {`OWN_IF`, `OWN_D`}.
- Sub-module `rv_arb_fair`: two-requester priority selection plus the `dwin` starvation counter, producing one-hot grants. `rv_mem_arbiter` instantiates it and owns the FSM, the latency counter and the muxing.

## Test plan
- **Fetch only:** `MEM_LAT`=1, `if_req` held, addresses 0,4,8 → `if_gnt` every cycle; `if_rvalid` each following cycle with `mem_rdata` words; `d_gnt` stays 0.
- **Conflict:** `MEM_LAT`=2, both `req` held continuously → grant order D,D,IF,D,D,IF, one issue every 2 cycles.
- **Store:** `d_we`=1, `addr`=0x64, `wdata`=0x19, `mask`=4'b0001 → `mem_en`/`mem_we` 1 with those values; `d_rvalid` after `MEM_LAT` cycles with `d_rdata`=0.
- **Back-to-back:** `MEM_LAT`=3, load then fetch → the second issue lands in the same cycle as the first `d_rvalid`; `if_rvalid` follows 3 cycles later.
- **Reset mid-access:** issue a load, drop `reset` at T+1 → all outputs 0 immediately; after release, no `rvalid`, `IDLE`, `dwin`=0.
